// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller, ALU and datapath.
// Pure declarations: no logic, no latency, no flow control.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FN    = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [1:0] FMT_R  = 2'b00;
  localparam logic [1:0] FMT_I  = 2'b01;
  localparam logic [1:0] FMT_LS = 2'b10;
  localparam logic [1:0] FMT_BR = 2'b11;

  localparam logic [3:0] OPC_BEQ  = 4'b0000;
  localparam logic [3:0] OPC_BNE  = 4'b0001;
  localparam logic [3:0] OPC_J    = 4'b0010;
  localparam logic [3:0] OPC_LI   = 4'b1001;
  localparam logic [3:0] OPC_LWI  = 4'b1011;
  localparam logic [3:0] OPC_SWI  = 4'b1100;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LWI,
    CLS_SWI,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_HALT,
    CLS_ILL
  } op_class_t;

  // ALU opcodes shared by R-type and I-type: 0000 and 0010..0111.
  function automatic logic opc_is_alu(input logic [3:0] opc);
    return (opc == 4'b0000) || ((opc >= 4'b0010) && (opc <= 4'b0111));
  endfunction

  function automatic logic opc_is_signed_imm(input logic [3:0] opc);
    return (opc == 4'b0010) || (opc == 4'b0011) || (opc == 4'b0111);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> IR/memory/datapath signal bundle.
// master = controller side, slave = memory/datapath side.
interface multicycle_ctrl_fsm_if #(
  parameter int WORD_SIZE = 32
);

  logic [WORD_SIZE-1:0] instr;
  logic                 alu_zero;
  logic                 mem_ready;

  logic                 mem_req;
  logic                 mem_we;
  logic                 mem_addr_sel;
  logic                 ir_write;
  logic                 pc_inc;
  logic                 pc_load;
  logic [1:0]           alu_op;
  logic [3:0]           alu_fn;
  logic                 alu_src_imm;
  logic                 imm_sext;
  logic                 reg_write;
  logic                 wb_from_mem;
  logic                 illegal;
  logic                 halted;

  modport master (
    input  instr, alu_zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_write, pc_inc, pc_load,
           alu_op, alu_fn, alu_src_imm, imm_sext, reg_write, wb_from_mem,
           illegal, halted
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_write, pc_inc, pc_load,
           alu_op, alu_fn, alu_src_imm, imm_sext, reg_write, wb_from_mem,
           illegal, halted
  );

endinterface

// File: rtl/ctrl_op_decode.sv
// Combinational {fmt,opc} classifier: instruction class, illegal flag, imm sign mode.
// Zero latency, no flow control.
module ctrl_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0] i_fmt,
  input  logic [3:0] i_opc,
  output op_class_t  o_class,
  output logic       o_illegal,
  output logic       o_imm_sext
);

  always_comb begin
    o_class = CLS_ILL;
    case (i_fmt)
      FMT_R: begin
        if (opc_is_alu(i_opc)) o_class = CLS_R;
      end
      FMT_I: begin
        if (opc_is_alu(i_opc) || (i_opc == OPC_LI)) o_class = CLS_I;
      end
      FMT_LS: begin
        if (i_opc == OPC_LWI)      o_class = CLS_LWI;
        else if (i_opc == OPC_SWI) o_class = CLS_SWI;
      end
      default: begin
        case (i_opc)
          OPC_BEQ:  o_class = CLS_BEQ;
          OPC_BNE:  o_class = CLS_BNE;
          OPC_J:    o_class = CLS_J;
          OPC_HALT: o_class = CLS_HALT;
          default:  o_class = CLS_ILL;
        endcase
      end
    endcase
  end

  assign o_illegal  = (o_class == CLS_ILL);
  assign o_imm_sext = (o_class == CLS_I) && opc_is_signed_imm(i_opc);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT); zero-wait latency R/I=4, LWI=5, SWI=4, branch/J=3.
// Memory backpressure: FETCH and MEM hold mem_req and stall until mem_ready.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_ir_op;
  logic [1:0] w_fmt;
  logic [3:0] w_opc;
  op_class_t  w_class;
  logic       w_illegal;
  logic       w_imm_sext;
  logic       w_fetch_done;
  logic       w_unused_instr;

  assign w_fmt          = r_ir_op[5:4];
  assign w_opc          = r_ir_op[3:0];
  assign w_fetch_done   = (r_state == ST_FETCH) && bus.mem_ready;
  assign w_unused_instr = ^bus.instr[WORD_SIZE-7:0];

  ctrl_op_decode u_decode (
    .i_fmt      (w_fmt),
    .i_opc      (w_opc),
    .o_class    (w_class),
    .o_illegal  (w_illegal),
    .o_imm_sext (w_imm_sext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_ir_op <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_fetch_done) r_ir_op <= bus.instr[WORD_SIZE-1 -: 6];
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (bus.mem_ready) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_illegal)              w_next_state = ST_FETCH;
        else if (w_class == CLS_HALT) w_next_state = ST_HALT;
        else                        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        case (w_class)
          CLS_R, CLS_I:     w_next_state = ST_WB;
          CLS_LWI, CLS_SWI: w_next_state = ST_MEM;
          default:          w_next_state = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) w_next_state = (w_class == CLS_LWI) ? ST_WB : ST_FETCH;
      end
      ST_WB:   w_next_state = ST_FETCH;
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_FETCH;
    endcase
  end

  // Outputs forced low while rst_n is asserted, so FETCH's mem_req first appears once reset lifts.
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_inc       = 1'b0;
    bus.pc_load      = 1'b0;
    bus.alu_op       = ALUOP_ADD;
    bus.alu_fn       = 4'b0000;
    bus.alu_src_imm  = 1'b0;
    bus.imm_sext     = 1'b0;
    bus.reg_write    = 1'b0;
    bus.wb_from_mem  = 1'b0;
    bus.illegal      = 1'b0;
    bus.halted       = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_inc   = bus.mem_ready;
        end
        ST_DECODE: begin
          bus.illegal = w_illegal;
        end
        ST_EXEC: begin
          // alu_fn carries the opcode field only while the ALU is in use.
          bus.alu_fn = w_opc;
          case (w_class)
            CLS_R: begin
              bus.alu_op = ALUOP_FN;
            end
            CLS_I: begin
              bus.alu_op      = ALUOP_FN;
              bus.alu_src_imm = 1'b1;
              bus.imm_sext    = w_imm_sext;
            end
            CLS_LWI, CLS_SWI: begin
              bus.alu_op      = ALUOP_PASSB;
              bus.alu_src_imm = 1'b1;
            end
            CLS_BEQ: begin
              bus.alu_op  = ALUOP_SUB;
              bus.pc_load = bus.alu_zero;
            end
            CLS_BNE: begin
              bus.alu_op  = ALUOP_SUB;
              bus.pc_load = !bus.alu_zero;
            end
            CLS_J: begin
              bus.alu_op  = ALUOP_ADD;
              bus.pc_load = 1'b1;
            end
            default: begin
              bus.alu_op = ALUOP_ADD;
            end
          endcase
        end
        ST_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we       = (w_class == CLS_SWI);
        end
        ST_WB: begin
          bus.reg_write   = 1'b1;
          bus.wb_from_mem = (w_class == CLS_LWI);
        end
        ST_HALT: begin
          bus.halted = 1'b1;
        end
        default: begin
          bus.halted = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Cycle-by-cycle bench for multicycle_ctrl_fsm: vector table plus hand-written corner sequences.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_inc;
    logic       pc_load;
    logic [1:0] alu_op;
    logic [3:0] alu_fn;
    logic       alu_src_imm;
    logic       imm_sext;
    logic       reg_write;
    logic       wb_from_mem;
    logic       illegal;
    logic       halted;
  } out_t;

  typedef struct {
    logic        rstv;
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    out_t        exp;
    logic [63:0] name;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vec_t        vecs[$];
  out_t        exp_q[$];
  logic [63:0] name_q[$];

  multicycle_ctrl_fsm_if #(.WORD_SIZE(32)) bus ();

  multicycle_ctrl_fsm #(.WORD_SIZE(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic out_t e_none();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t e_fetch(input logic rdy);
    out_t o = '0;
    o.mem_req  = 1'b1;
    o.ir_write = rdy;
    o.pc_inc   = rdy;
    return o;
  endfunction

  function automatic out_t e_exec(input logic [1:0] op, input logic [3:0] fn,
                                  input logic src, input logic sext, input logic pcl);
    out_t o = '0;
    o.alu_op      = op;
    o.alu_fn      = fn;
    o.alu_src_imm = src;
    o.imm_sext    = sext;
    o.pc_load     = pcl;
    return o;
  endfunction

  function automatic out_t e_mem(input logic we);
    out_t o = '0;
    o.mem_req      = 1'b1;
    o.mem_addr_sel = 1'b1;
    o.mem_we       = we;
    return o;
  endfunction

  function automatic out_t e_wb(input logic fm);
    out_t o = '0;
    o.reg_write   = 1'b1;
    o.wb_from_mem = fm;
    return o;
  endfunction

  function automatic out_t e_ill();
    out_t o = '0;
    o.illegal = 1'b1;
    return o;
  endfunction

  function automatic out_t e_halt();
    out_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  function automatic out_t actual();
    out_t a;
    a.mem_req      = bus.mem_req;
    a.mem_we       = bus.mem_we;
    a.mem_addr_sel = bus.mem_addr_sel;
    a.ir_write     = bus.ir_write;
    a.pc_inc       = bus.pc_inc;
    a.pc_load      = bus.pc_load;
    a.alu_op       = bus.alu_op;
    a.alu_fn       = bus.alu_fn;
    a.alu_src_imm  = bus.alu_src_imm;
    a.imm_sext     = bus.imm_sext;
    a.reg_write    = bus.reg_write;
    a.wb_from_mem  = bus.wb_from_mem;
    a.illegal      = bus.illegal;
    a.halted       = bus.halted;
    return a;
  endfunction

  task automatic check_out();
    out_t        a;
    out_t        e;
    logic [63:0] nm;
    a  = actual();
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later.
  task automatic step(input logic rstv, input logic [31:0] ins, input logic z,
                      input logic rdy, input out_t e, input logic [63:0] nm);
    @(negedge clk);
    rst_n         = rstv;
    bus.instr     = ins;
    bus.alu_zero  = z;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    check_out();
  endtask

  task automatic add(input logic [31:0] ins, input logic z, input logic rdy,
                     input out_t e, input logic [63:0] nm);
    vec_t v;
    v.rstv  = 1'b1;
    v.instr = ins;
    v.zero  = z;
    v.rdy   = rdy;
    v.exp   = e;
    v.name  = nm;
    vecs.push_back(v);
  endtask

  // mem_ready is held high outside FETCH to show it is ignored there.
  task automatic add_alu(input logic [31:0] ins, input logic [3:0] fn, input logic src,
                         input logic sext, input logic [63:0] nm);
    add(ins, 1'b0, 1'b1, e_fetch(1'b1), nm);
    add(ins, 1'b0, 1'b1, e_none(), nm);
    add(ins, 1'b0, 1'b1, e_exec(2'b10, fn, src, sext, 1'b0), nm);
    add(ins, 1'b0, 1'b1, e_wb(1'b0), nm);
  endtask

  task automatic add_br(input logic [31:0] ins, input logic [1:0] op, input logic [3:0] fn,
                        input logic z, input logic pcl, input logic [63:0] nm);
    add(ins, z, 1'b1, e_fetch(1'b1), nm);
    add(ins, z, 1'b1, e_none(), nm);
    add(ins, z, 1'b1, e_exec(op, fn, 1'b0, 1'b0, pcl), nm);
  endtask

  task automatic add_ill(input logic [31:0] ins, input logic [63:0] nm);
    add(ins, 1'b0, 1'b1, e_fetch(1'b1), nm);
    add(ins, 1'b0, 1'b1, e_ill(), nm);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.instr     = 32'h0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b1;

    add_alu(32'h4800_FFFF, 4'b0010, 1'b1, 1'b1, "ADDI");
    add_alu(32'h0000_0000, 4'b0000, 1'b0, 1'b0, "R_0000");
    add_alu(32'h1C00_0000, 4'b0111, 1'b0, 1'b0, "R_0111");
    add_alu(32'h6400_0000, 4'b1001, 1'b1, 1'b0, "LI");
    add_alu(32'h5000_0000, 4'b0100, 1'b1, 1'b0, "I_0100");
    add_alu(32'h5C00_0000, 4'b0111, 1'b1, 1'b1, "I_0111");
    add_br(32'hC400_0000, 2'b01, 4'b0001, 1'b0, 1'b1, "BNE_Z0");
    add_br(32'hC400_0000, 2'b01, 4'b0001, 1'b1, 1'b0, "BNE_Z1");
    add_br(32'hC000_0000, 2'b01, 4'b0000, 1'b1, 1'b1, "BEQ_Z1");
    add_br(32'hC000_0000, 2'b01, 4'b0000, 1'b0, 1'b0, "BEQ_Z0");
    add_br(32'hC800_0000, 2'b00, 4'b0010, 1'b0, 1'b1, "J");
    add(32'hB000_0000, 1'b0, 1'b1, e_fetch(1'b1), "SWI");
    add(32'hB000_0000, 1'b0, 1'b1, e_none(), "SWI");
    add(32'hB000_0000, 1'b0, 1'b1, e_exec(2'b11, 4'b1100, 1'b1, 1'b0, 1'b0), "SWI");
    add(32'hB000_0000, 1'b0, 1'b1, e_mem(1'b1), "SWI");
    add_ill(32'h6800_0000, "ILL_I");
    add_ill(32'hCC00_0000, "ILL_BR");
    add_ill(32'h8000_0000, "ILL_LS");

    // Reset hold with mem_ready high: nothing may leak out.
    step(1'b0, 32'h0, 1'b0, 1'b1, e_none(), "RST");
    step(1'b0, 32'h0, 1'b0, 1'b1, e_none(), "RST");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rstv, vecs[i].instr, vecs[i].zero, vecs[i].rdy, vecs[i].exp, vecs[i].name);

    // LWI: 3 FETCH waits, 2 MEM waits, 10 cycles total.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'hAC00_0000, 1'b0, 1'b0, e_fetch(1'b0), "LWI_FW");
    step(1'b1, 32'hAC00_0000, 1'b0, 1'b1, e_fetch(1'b1), "LWI_F");
    step(1'b1, 32'hAC00_0000, 1'b0, 1'b1, e_none(), "LWI_D");
    step(1'b1, 32'hAC00_0000, 1'b0, 1'b1, e_exec(2'b11, 4'b1011, 1'b1, 1'b0, 1'b0), "LWI_E");
    for (int i = 0; i < 2; i++)
      step(1'b1, 32'hAC00_0000, 1'b0, 1'b0, e_mem(1'b0), "LWI_MW");
    step(1'b1, 32'hAC00_0000, 1'b0, 1'b1, e_mem(1'b0), "LWI_M");
    step(1'b1, 32'hAC00_0000, 1'b0, 1'b1, e_wb(1'b1), "LWI_WB");

    // SWI aborted by reset while MEM is stalled.
    step(1'b1, 32'hB000_0000, 1'b0, 1'b1, e_fetch(1'b1), "SWR_F");
    step(1'b1, 32'hB000_0000, 1'b0, 1'b0, e_none(), "SWR_D");
    step(1'b1, 32'hB000_0000, 1'b0, 1'b0, e_exec(2'b11, 4'b1100, 1'b1, 1'b0, 1'b0), "SWR_E");
    step(1'b1, 32'hB000_0000, 1'b0, 1'b0, e_mem(1'b1), "SWR_M");
    step(1'b0, 32'hB000_0000, 1'b0, 1'b0, e_none(), "SWR_RST");
    step(1'b1, 32'hB000_0000, 1'b0, 1'b0, e_fetch(1'b0), "SWR_F2");

    // Illegal instruction, then HALT held until reset.
    step(1'b1, 32'h2000_0000, 1'b0, 1'b1, e_fetch(1'b1), "IL_F");
    step(1'b1, 32'h2000_0000, 1'b0, 1'b1, e_ill(), "IL_D");
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b1, e_fetch(1'b1), "HLT_F");
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b1, e_none(), "HLT_D");
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'hFC00_0000, 1'b0, 1'b1, e_halt(), "HALT");
    step(1'b0, 32'h0000_0000, 1'b0, 1'b0, e_none(), "HLT_RST");
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0, e_fetch(1'b0), "HLT_F2");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d leftover want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
